// File: rtl/pmod_jstk_interface.sv
// SPI mode-0 master for the Digilent PmodJSTK: one 5-byte full-duplex transfer per
// rising edge of sndRec, command byte out, X/Y/button frame collected into DOUT.
module pmod_jstk_interface #(
  parameter int SCLK_HALF_DIV   = 750,
  parameter int SS_SETUP_CYCLES = 1500,
  parameter int BYTE_GAP_CYCLES = 1000,
  parameter int NUM_BYTES       = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     sndRec,
  input  logic [7:0]               DIN,
  input  logic                     MISO,
  output logic                     MOSI,
  output logic                     SCLK,
  output logic                     SS,
  output logic [8*NUM_BYTES-1:0]   DOUT
);

  localparam int FRAME_W = 8 * NUM_BYTES;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [15:0] SETUP_LAST = 16'(SS_SETUP_CYCLES - 1);
  localparam logic [15:0] HALF_LAST  = 16'(SCLK_HALF_DIV - 1);
  localparam logic [15:0] GAP_LAST   = 16'(BYTE_GAP_CYCLES - 1);
  localparam logic [2:0]  LAST_BYTE  = 3'(NUM_BYTES - 1);

  logic               snd_meta_r;
  logic               snd_sync_r;
  logic               snd_prev_r;
  logic               snd_rise_s;
  logic [2:0]         state_r;
  logic [15:0]        cnt_r;
  logic [2:0]         bit_idx_r;
  logic [2:0]         byte_idx_r;
  logic [7:0]         tx_byte_r;
  logic [7:0]         rx_shift_r;
  logic [FRAME_W-1:0] frame_r;
  logic [FRAME_W-1:0] dout_r;
  logic               sclk_r;
  logic               ss_r;

  assign snd_rise_s = snd_sync_r & ~snd_prev_r;

  // MOSI is the MSB of the transmit shift register; it is zero whenever idle.
  assign MOSI = tx_byte_r[7];
  assign SCLK = sclk_r;
  assign SS   = ss_r;
  assign DOUT = dout_r;

  // Two-flop synchroniser for sndRec plus a delayed copy for rise detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      snd_meta_r <= 1'b0;
      snd_sync_r <= 1'b0;
      snd_prev_r <= 1'b0;
    end else begin
      snd_meta_r <= sndRec;
      snd_sync_r <= snd_meta_r;
      snd_prev_r <= snd_sync_r;
    end
  end

  // Transaction sequencer: SS setup, 8-bit mode-0 bytes, inter-byte gaps, atomic DOUT load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 16'd0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 3'd0;
      tx_byte_r  <= 8'h00;
      rx_shift_r <= 8'h00;
      frame_r    <= '0;
      dout_r     <= '0;
      sclk_r     <= 1'b0;
      ss_r       <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (snd_rise_s) begin
            tx_byte_r  <= DIN;
            byte_idx_r <= 3'd0;
            bit_idx_r  <= 3'd0;
            cnt_r      <= 16'd0;
            ss_r       <= 1'b0;
            state_r    <= ST_SETUP;
          end else begin
            cnt_r <= 16'd0;
          end
        end
        ST_SETUP: begin
          if (cnt_r == SETUP_LAST) begin
            cnt_r   <= 16'd0;
            state_r <= ST_XFER;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_XFER: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r <= 16'd0;
            if (!sclk_r) begin
              sclk_r     <= 1'b1;
              rx_shift_r <= {rx_shift_r[6:0], MISO};
            end else begin
              // Falling edge: advance MOSI; after bit 7 the zero fill is the next byte's MSB.
              sclk_r    <= 1'b0;
              tx_byte_r <= {tx_byte_r[6:0], 1'b0};
              bit_idx_r <= bit_idx_r + 3'd1;
              if (bit_idx_r == 3'd7) begin
                frame_r    <= {frame_r[FRAME_W-9:0], rx_shift_r};
                byte_idx_r <= byte_idx_r + 3'd1;
                if (byte_idx_r == LAST_BYTE) begin
                  state_r <= ST_DONE;
                end else begin
                  state_r <= ST_GAP;
                end
              end
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r   <= 16'd0;
            state_r <= ST_XFER;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_DONE: begin
          ss_r      <= 1'b1;
          tx_byte_r <= 8'h00;
          dout_r    <= frame_r;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          sclk_r  <= 1'b0;
          ss_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_jstk_interface.sv
// Directed bench for pmod_jstk_interface: behavioural joystick slave, bus monitor
// and hand-computed frames covering reset, framing, timing, busy-drop and sampling.
module tb_pmod_jstk_interface;

  localparam int HALF  = 2;
  localparam int SETUP = 4;
  localparam int GAP   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snd_rec = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        miso;
  logic        mosi;
  logic        sclk;
  logic        ss;
  logic [39:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pmod_jstk_interface #(
    .SCLK_HALF_DIV  (HALF),
    .SS_SETUP_CYCLES(SETUP),
    .BYTE_GAP_CYCLES(GAP),
    .NUM_BYTES      (5)
  ) dut (
    .CLK   (clk),
    .RST   (rst),
    .sndRec(snd_rec),
    .DIN   (din),
    .MISO  (miso),
    .MOSI  (mosi),
    .SCLK  (sclk),
    .SS    (ss),
    .DOUT  (dout)
  );

  // Slave model: bit index advances on every SCLK falling edge, frame MSB first.
  logic [39:0] slave_frame = 40'h0;
  int          slave_falls = 0;
  int          falls_base  = 0;
  logic        force_en    = 1'b0;
  logic        force_val   = 1'b0;
  logic        slave_bit_s;

  always @(negedge sclk) slave_falls <= slave_falls + 1;

  always_comb begin
    int idx;
    idx = slave_falls - falls_base;
    slave_bit_s = 1'b0;
    if (idx >= 0 && idx < 40) slave_bit_s = slave_frame[6'(39 - idx)];
    miso = force_en ? force_val : slave_bit_s;
  end

  // Bus monitor sampled on the inactive clock edge.
  int          cyc = 0;
  logic        ss_prev = 1'b1;
  logic        sclk_prev = 1'b0;
  logic [39:0] dout_prev = 40'h0;
  int          frame_rises = 0;
  logic [39:0] mosi_cap = 40'h0;
  logic [39:0] last_mosi = 40'h0;
  int          last_rises = 0;
  int          t_ss_fall = 0;
  int          t_sclk_fall = 0;
  int          setup_meas = 0;
  int          gap_meas = 0;
  int          ss_fall_cnt = 0;
  int          ss_rise_cnt = 0;
  int          dout_chg = 0;
  int          dout_bad = 0;
  int          frame_bad = 0;
  int          sclk_bad = 0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    ss_prev   <= ss;
    sclk_prev <= sclk;
    dout_prev <= dout;
    if (ss_prev && !ss) begin
      ss_fall_cnt <= ss_fall_cnt + 1;
      t_ss_fall   <= cyc;
      frame_rises <= 0;
      mosi_cap    <= 40'h0;
      falls_base  <= slave_falls;
    end
    if (!ss_prev && ss) begin
      ss_rise_cnt <= ss_rise_cnt + 1;
      last_mosi   <= mosi_cap;
      last_rises  <= frame_rises;
      if (!rst && frame_rises != 40) frame_bad <= frame_bad + 1;
    end
    if (!sclk_prev && sclk) begin
      frame_rises <= frame_rises + 1;
      mosi_cap    <= {mosi_cap[38:0], mosi};
      if (frame_rises == 0) setup_meas <= cyc - t_ss_fall;
      if (frame_rises == 8) gap_meas <= cyc - t_sclk_fall;
    end
    if (sclk_prev && !sclk) t_sclk_fall <= cyc;
    if (!rst && ss && sclk) sclk_bad <= sclk_bad + 1;
    if (dout !== dout_prev) begin
      dout_chg <= dout_chg + 1;
      if (!ss) dout_bad <= dout_bad + 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
    n_checks++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    snd_rec = 1'b1;
    repeat (3) @(negedge clk);
    snd_rec = 1'b0;
  endtask

  task automatic wait_ss(input logic lvl, input int budget, input string tag);
    int n;
    n = 0;
    while (ss !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 64'(ss), 64'(lvl));
  endtask

  task automatic wait_rises(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (frame_rises < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 64'(frame_rises >= target), 64'd1);
  endtask

  task automatic wait_falls(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while ((slave_falls - falls_base) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 64'((slave_falls - falls_base) >= target), 64'd1);
  endtask

  initial begin
    int  base_fall;
    int  base_chg;
    int  base_rise;
    logic got_a;
    logic got_b;
    logic din_changed;

    // Reset held with sndRec toggling.
    repeat (6) begin
      @(negedge clk);
      snd_rec = ~snd_rec;
    end
    check_val("rst_ss", 64'(ss), 64'd1);
    check_val("rst_sclk", 64'(sclk), 64'd0);
    check_val("rst_mosi", 64'(mosi), 64'd0);
    check_val("rst_dout", 64'(dout), 64'h0);
    snd_rec = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while SCLK high and MOSI=1 (bit 6 of 8'h83) aborts at once.
    din = 8'h83;
    slave_frame = 40'h5A03C30105;
    start_frame();
    wait_ss(1'b0, 20, "abort_ss_low");
    wait_rises(7, 200, "abort_reach_bit7");
    rst = 1'b1;
    #1;
    check_val("abort_ss", 64'(ss), 64'd1);
    check_val("abort_sclk", 64'(sclk), 64'd0);
    check_val("abort_mosi", 64'(mosi), 64'd0);
    base_fall = ss_fall_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (250) @(negedge clk);
    check_val("abort_dout", 64'(dout), 64'h0);
    check_val("abort_no_restart", 64'(ss_fall_cnt - base_fall), 64'd0);

    // Single frame.
    start_frame();
    wait_ss(1'b0, 20, "f1_ss_low");
    wait_ss(1'b1, 400, "f1_ss_high");
    repeat (2) @(negedge clk);
    check_val("f1_mosi", 64'(last_mosi), 64'h8300000000);
    check_val("f1_rises", 64'(last_rises), 64'd40);
    check_val("f1_dout", 64'(dout), 64'h5A03C30105);

    // Timing against parameters.
    check_val("setup_cycles", 64'(setup_meas), 64'(SETUP + HALF));
    check_val("gap_cycles", 64'(gap_meas), 64'(GAP + HALF));

    // Busy-drop: ten sndRec pulses inside one transfer.
    slave_frame = 40'h1122334455;
    din = 8'h01;
    base_fall = ss_fall_cnt;
    base_chg = dout_chg;
    start_frame();
    wait_ss(1'b0, 20, "busy_ss_low");
    repeat (10) begin
      @(negedge clk);
      snd_rec = 1'b1;
      repeat (2) @(negedge clk);
      snd_rec = 1'b0;
      repeat (2) @(negedge clk);
    end
    check_val("busy_dout_hold", 64'(dout), 64'h5A03C30105);
    wait_ss(1'b1, 400, "busy_ss_high");
    repeat (30) @(negedge clk);
    check_val("busy_frames", 64'(ss_fall_cnt - base_fall), 64'd1);
    check_val("busy_dout_steps", 64'(dout_chg - base_chg), 64'd1);
    check_val("busy_dout", 64'(dout), 64'h1122334455);

    // Back-to-back with free-running sndRec, DIN changed during the first frame.
    slave_frame = 40'hFFFFFFFFFF;
    din = 8'hA5;
    base_fall = ss_fall_cnt;
    base_rise = ss_rise_cnt;
    got_a = 1'b0;
    got_b = 1'b0;
    din_changed = 1'b0;
    for (int c = 0; c < 1000 && !got_b; c++) begin
      @(negedge clk);
      snd_rec = ((c % 8) < 4);
      if (!din_changed && ss_fall_cnt == base_fall + 1 && frame_rises >= 12) begin
        din = 8'h3C;
        din_changed = 1'b1;
      end
      if (!got_a && ss_rise_cnt == base_rise + 1) begin
        check_val("b2b_a_mosi", 64'(last_mosi), 64'hA500000000);
        check_val("b2b_a_dout", 64'(dout), 64'hFFFFFFFFFF);
        got_a = 1'b1;
      end
      if (!got_b && ss_rise_cnt == base_rise + 2) begin
        check_val("b2b_b_mosi", 64'(last_mosi), 64'h3C00000000);
        check_val("b2b_b_dout", 64'(dout), 64'hFFFFFFFFFF);
        got_b = 1'b1;
      end
    end
    snd_rec = 1'b0;
    check_val("b2b_two_frames", 64'(got_b), 64'd1);
    repeat (6) @(negedge clk);
    wait_ss(1'b1, 400, "b2b_drain");
    repeat (5) @(negedge clk);

    // MISO glitches: a short one before rise 2 is ignored, one held across rise 34 is taken.
    slave_frame = 40'h123456789A;
    din = 8'h00;
    start_frame();
    wait_ss(1'b0, 20, "glitch_ss_low");
    repeat (2) @(negedge clk);
    wait_falls(1, 100, "glitch_fall1");
    force_val = ~slave_bit_s;
    force_en = 1'b1;
    @(negedge clk);
    force_en = 1'b0;
    wait_falls(33, 400, "glitch_fall33");
    force_val = ~slave_bit_s;
    force_en = 1'b1;
    wait_rises(34, 20, "glitch_rise34");
    force_en = 1'b0;
    wait_ss(1'b1, 400, "glitch_ss_high");
    repeat (2) @(negedge clk);
    check_val("glitch_dout", 64'(dout), 64'h12345678DA);

    // Whole-run bus invariants.
    check_val("ss_mid_frame_rise", 64'(frame_bad), 64'd0);
    check_val("sclk_while_ss_high", 64'(sclk_bad), 64'd0);
    check_val("dout_change_ss_low", 64'(dout_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmod_jstk_interface.md
Name: pmod_jstk_interface

Overview:
SPI master for the Digilent PmodJSTK two-axis joystick. On each rising edge of a request strobe it runs one 5-byte full-duplex SPI transaction: it sends a command byte (LED control) and collects X, Y and button data into a 40-bit word. It sits between the board pins (SS/SCLK/MOSI/MISO) and game logic, which extracts joystick position and buttons from DOUT.

Parameters:
SCLK_HALF_DIV, 750, CLK cycles per SCLK half-period (100 MHz -> ~66.7 kHz SCLK)
SS_SETUP_CYCLES, 1500, CLK cycles from SS falling to first SCLK edge (15 us)
BYTE_GAP_CYCLES, 1000, idle CLK cycles between bytes with SCLK low and SS held low (10 us)
NUM_BYTES, 5, bytes per transaction (fixed at 5; DOUT width depends on it)

Ports:
CLK  in  1  system clock, all logic on its rising edge
RST  in  1  asynchronous active-high reset
sndRec  in  1  transaction request; a 0->1 transition starts a transfer; may be a free-running clock
DIN  in  8  command byte; bits[1:0] drive the PmodJSTK LEDs
MISO  in  1  serial data from joystick
MOSI  out  1  serial data to joystick
SCLK  out  1  SPI clock, mode 0
SS  out  1  slave select, active low
DOUT  out  40  last complete received frame

Behaviour:
- Reset (async, RST=1): SS=1, SCLK=0, MOSI=0, DOUT=40'h0, FSM=IDLE, all counters and shift registers cleared. Reset mid-transfer aborts immediately. DOUT keeps 0 until a full frame completes after reset.
- sndRec is synchronised through 2 flops. A rising edge is detected on the synchronised value. Edges are honoured only in IDLE; edges during a transfer are dropped, not queued.
- FSM states and transitions:
  - IDLE: on edge detect, latch DIN into tx_byte and clear the byte index, set SS=0, go to SETUP.
  - SETUP: count SS_SETUP_CYCLES, then go to XFER.
  - XFER: 8 bits, MSB first, SPI mode 0.
    - MOSI presents the bit before the SCLK rising edge.
    - After SCLK_HALF_DIV cycles SCLK rises and MISO is sampled into rx shift register.
    - After another SCLK_HALF_DIV cycles SCLK falls and MOSI advances.
    - After the 8th falling edge, append the rx byte to the frame and go to GAP, or to DONE if this was the 5th byte.
  - GAP: SCLK=0, SS=0 for BYTE_GAP_CYCLES; the next byte's MSB is on MOSI; go to XFER.
  - DONE: SS=1, MOSI=0, DOUT <= assembled frame in a single cycle (atomic update), go to IDLE.
- Transmit bytes: byte0 = latched DIN; bytes1..4 = 8'h00. DIN changes during a transfer have no effect.
- DOUT packing, first received byte most significant:
  - DOUT[39:32] = byte0 (X low 8 bits)
  - DOUT[31:24] = byte1 (X high, bits[1:0] valid)
  - DOUT[23:16] = byte2 (Y low)
  - DOUT[15:8] = byte3 (Y high, bits[1:0] valid)
  - DOUT[7:0] = byte4 (buttons: bit0 stick button, bit1 BTN1, bit2 BTN2)
  - Upper bits of bytes 1, 3 and 4 are passed through unmodified.
- SCLK is exactly 0 whenever SS=1. SS stays low continuously across all 5 bytes. There are exactly 40 SCLK pulses per transaction.
- Transaction length in CLK cycles: 2 (sync) + 1 + SS_SETUP_CYCLES + 5*16*SCLK_HALF_DIV + 4*BYTE_GAP_CYCLES + 1. This is ±2 cycles of the edge-detect pipeline. DOUT is valid on the cycle after SS returns high.
- The next transaction can start at the first sndRec rising edge detected after returning to IDLE.

Test Plan:
Use SCLK_HALF_DIV=2, SS_SETUP_CYCLES=4, BYTE_GAP_CYCLES=3 for simulation speed.
1. Reset: hold RST with sndRec toggling -> SS=1, SCLK=0, MOSI=0, DOUT=0. Assert RST mid-byte -> same values in the same cycle; no DOUT update.
2. Single frame: DIN=8'h83; slave model returns 5A,03,C3,01,05 -> MOSI carries 83,00,00,00,00 MSB-first; exactly 40 SCLK rises; DOUT=40'h5A03C30105.
3. Timing: measure SS fall to first SCLK rise (>= SS_SETUP_CYCLES+SCLK_HALF_DIV) and inter-byte SCLK-low gap (>= BYTE_GAP_CYCLES) -> values match parameters; SS never rises mid-frame.
4. Busy-drop: pulse sndRec 10 times during one transfer -> exactly one frame. DOUT is unchanged until DONE and then changes in one cycle (no partial values).
5. Back-to-back with free-running sndRec (period 8 CLK) and DIN changed mid-frame -> second frame sends the new DIN only in its byte0; the slave returns FF x5 -> DOUT=40'hFFFFFFFFFF.
6. Mode check: MISO is changed only on SCLK falling edges in the slave model -> sampled bits are correct. A MISO glitch placed between a falling edge and the next rise is captured only if still present at the rise.
